// File: rtl/cbd_timer_pkg.sv
// -----------------------------------------------------------------------------
// cbd_timer_pkg
// Shared types and constants for the cascaded down-counter interval timer.
//   - state_t       : controller sequencing states
//   - ADDR_*        : register-write port addresses
//   - MODE_*        : CONTROL register mode bit index and encodings
//   - NIBBLE_W      : width of one counter stage
// -----------------------------------------------------------------------------
package cbd_timer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_RELOAD   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL  = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;

  localparam int   MODE_BIT      = 0;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : cbd_timer_pkg

// File: rtl/cbd_nibble_stage.sv
// -----------------------------------------------------------------------------
// cbd_nibble_stage
// One 4-bit down-counter stage of the timer chain.
// Ports:
//   i_clk  : rising-edge clock
//   i_cd   : asynchronous active-high clear
//   i_ld   : parallel load of i_d (highest priority)
//   i_ps   : synchronous preset to all-ones
//   i_en   : count enable
//   i_cai  : borrow in; the stage decrements when i_en and i_cai are high
//   i_d    : parallel load value
//   o_q    : stage value
//   o_cao  : borrow out (i_cai while the stage sits at zero)
// -----------------------------------------------------------------------------
module cbd_nibble_stage
  import cbd_timer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_cd,
  input  logic                i_ld,
  input  logic                i_ps,
  input  logic                i_en,
  input  logic                i_cai,
  input  logic [NIBBLE_W-1:0] i_d,
  output logic [NIBBLE_W-1:0] o_q,
  output logic                o_cao
);

  logic [NIBBLE_W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_cd) begin
    if (i_cd) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_ps) begin
      r_q <= '1;
    end else if (i_en && i_cai) begin
      r_q <= r_q - NIBBLE_W'(1);
    end
  end

  // Borrow out is purely combinational so a whole-chain borrow settles
  // within the cycle; this also makes the top stage's o_cao a zero detect.
  assign o_q   = r_q;
  assign o_cao = i_cai & (r_q == '0);

endmodule : cbd_nibble_stage

// File: rtl/cbd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// cbd_timer_ctrl
// Programmable interval timer: sequences a cascade of 4-bit down-counter
// stages through IDLE/LOAD/RUN/FIN, with a prescaler, reload register and
// one-shot / periodic expiry.
//
// Optional build macro: CBD_TIMER_GATE_EN adds i_gate; while i_gate is low in
// RUN the prescaler and chain freeze and no expiry is produced. Without the
// macro the timer behaves as if the gate were always high.
//
// Ports:
//   i_clk      : rising-edge clock
//   i_cdn      : asynchronous active-low clear of the whole block
//   i_wr_en    : register write strobe
//   i_wr_addr  : 0 RELOAD, 1 CONTROL (bit0 mode), 2 PRESCALE, 3 ignored
//   i_wr_data  : write data, truncated/zero-extended to the target register
//   i_start    : start / restart request (one cycle)
//   i_stop     : stop request (one cycle), wins over i_start
//   i_gate     : count gate (only with CBD_TIMER_GATE_EN)
//   o_count    : current chain value
//   o_expire   : one-cycle terminal-count pulse
//   o_busy     : high in LOAD or RUN
//   o_done     : sticky one-shot completion flag
// -----------------------------------------------------------------------------
module cbd_timer_ctrl
  import cbd_timer_pkg::*;
#(
  parameter int NIBBLES    = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_cdn,
  input  logic                  i_wr_en,
  input  logic [1:0]            i_wr_addr,
  input  logic [4*NIBBLES-1:0]  i_wr_data,
  input  logic                  i_start,
  input  logic                  i_stop,
`ifdef CBD_TIMER_GATE_EN
  input  logic                  i_gate,
`endif
  output logic [4*NIBBLES-1:0]  o_count,
  output logic                  o_expire,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = 4 * NIBBLES;

  state_t                r_state;
  logic [CW-1:0]         r_reload;
  logic                  r_mode;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_done;

  logic                  w_gate;
  logic                  w_cd;
  logic                  w_run_act;
  logic                  w_tick;
  logic                  w_tick_act;
  logic                  w_zero_tick;
  logic                  w_load;
  logic                  w_ld;
  logic                  w_en;
  logic [CW-1:0]         w_count;
  logic [NIBBLES-1:0]    w_cao;

`ifdef CBD_TIMER_GATE_EN
  assign w_gate = i_gate;
`else
  assign w_gate = 1'b1;
`endif

  // Stage clear is the inverted block clear and nothing else.
  assign w_cd = ~i_cdn;

  // RUN work happens only when gated in and not being stopped this cycle.
  assign w_run_act  = (r_state == ST_RUN) & w_gate & ~i_stop;
  assign w_tick     = (r_presc == '0);
  assign w_tick_act = w_run_act & w_tick;

  // The tick is fed into the bottom of the chain as a borrow; it reaches the
  // top only when every stage is zero, i.e. a tick with COUNT==0.
  assign w_zero_tick = w_cao[NIBBLES-1];

  assign w_load = (r_state == ST_LOAD) & ~i_stop;
  assign w_ld   = w_load | (w_zero_tick & (r_mode == MODE_PERIODIC));
  // Never let the chain wrap below zero: decrement only on a non-zero tick.
  assign w_en   = w_tick_act & ~w_zero_tick;

  // ---------------------------------------------------------------------------
  // Counter chain
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_stage
      logic w_cai;
      if (gi == 0) begin : g_first
        assign w_cai = w_tick_act;
      end else begin : g_rest
        assign w_cai = w_cao[gi-1];
      end

      cbd_nibble_stage u_stage (
        .i_clk (i_clk),
        .i_cd  (w_cd),
        .i_ld  (w_ld),
        .i_ps  (1'b0),
        .i_en  (w_en),
        .i_cai (w_cai),
        .i_d   (r_reload[NIBBLE_W*gi +: NIBBLE_W]),
        .o_q   (w_count[NIBBLE_W*gi +: NIBBLE_W]),
        .o_cao (w_cao[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Configuration registers. A reload in the same cycle as a write still sees
  // the old value because both read the register before this edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_cdn) begin
    if (!i_cdn) begin
      r_reload   <= '0;
      r_mode     <= MODE_ONESHOT;
      r_prescale <= '0;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        ADDR_RELOAD:   r_reload   <= i_wr_data;
        ADDR_CONTROL:  r_mode     <= i_wr_data[MODE_BIT];
        ADDR_PRESCALE: r_prescale <= PRESCALE_W'(i_wr_data);
        default:       ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer, prescaler and DONE flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_cdn) begin
    if (!i_cdn) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else if (i_stop) begin
      // Stop freezes the prescaler and chain; DONE keeps its value.
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_presc <= r_prescale;
          r_done  <= 1'b0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_gate) begin
            if (w_tick) begin
              r_presc <= r_prescale;
            end else begin
              r_presc <= r_presc - PRESCALE_W'(1);
            end
          end
          if (w_zero_tick && (r_mode == MODE_ONESHOT)) begin
            r_done <= 1'b1;
          end
          // A restart overrides the one-shot finish but the expiry this
          // cycle is still reported.
          if (i_start) begin
            r_state <= ST_LOAD;
          end else if (w_zero_tick && (r_mode == MODE_ONESHOT)) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (i_start) begin
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_count  = w_count;
  assign o_expire = w_zero_tick;
  assign o_busy   = (r_state == ST_LOAD) | (r_state == ST_RUN);
  assign o_done   = r_done;

endmodule : cbd_timer_ctrl
